// File: rtl/bram_read_arbiter.sv
// Round-robin sharing of one BRAM read port between two requesters. Each read beat is
// steered back only to the requester that issued it. Per-requester grant counters saturate.
module bram_read_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 512,
  parameter int RD_LATENCY = 2,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic [ADDR_W-1:0] addr_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic [ADDR_W-1:0] addr_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [CNT_W-1:0]  grant_count_0,
  output logic [CNT_W-1:0]  grant_count_1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]     last_addr_q, last_addr_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d, id_q, id_d;
  logic [RD_LATENCY:0]   vld_shift_s, id_shift_s;
  logic [CNT_W-1:0]      cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                  gnt0_s, gnt1_s, issue_s;
  logic [ADDR_W-1:0]     issue_addr_s;

  // Grant selection; rr_ptr only matters when both requesters contend
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case ({req_1, req_0})
        2'b01: gnt0_s = 1'b1;
        2'b10: gnt1_s = 1'b1;
        2'b11: begin
          if (rr_ptr_q) gnt1_s = 1'b1;
          else          gnt0_s = 1'b1;
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Next-state for pointer, address hold, response pipe and counters
  always_comb begin
    issue_s      = gnt0_s | gnt1_s;
    issue_addr_s = gnt1_s ? addr_1 : addr_0;
    rr_ptr_d     = rr_ptr_q;
    last_addr_d  = last_addr_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (gnt0_s)      rr_ptr_d = 1'b1;
    else if (gnt1_s) rr_ptr_d = 1'b0;
    else             rr_ptr_d = rr_ptr_q;
    if (issue_s) last_addr_d = issue_addr_s;
    else         last_addr_d = last_addr_q;
    // Stage 0 takes the new issue; the top bit of the shift vector falls off the tail
    vld_shift_s = {vld_q, issue_s};
    id_shift_s  = {id_q, gnt1_s};
    vld_d       = vld_shift_s[RD_LATENCY-1:0];
    id_d        = id_shift_s[RD_LATENCY-1:0];
    if (gnt0_s && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_ONE;
    else                               cnt0_d = cnt0_q;
    if (gnt1_s && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_ONE;
    else                               cnt1_d = cnt1_q;
  end

  // State registers; reset drops any in-flight reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= 1'b0;
      last_addr_q <= {ADDR_W{1'b0}};
      vld_q       <= {RD_LATENCY{1'b0}};
      id_q        <= {RD_LATENCY{1'b0}};
      cnt0_q      <= {CNT_W{1'b0}};
      cnt1_q      <= {CNT_W{1'b0}};
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      last_addr_q <= last_addr_d;
      vld_q       <= vld_d;
      id_q        <= id_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign gnt_0         = gnt0_s;
  assign gnt_1         = gnt1_s;
  assign bram_addr     = issue_s ? issue_addr_s : last_addr_q;
  assign rvalid_0      = vld_q[RD_LATENCY-1] & ~id_q[RD_LATENCY-1];
  assign rvalid_1      = vld_q[RD_LATENCY-1] &  id_q[RD_LATENCY-1];
  assign rdata_0       = rvalid_0 ? bram_dout : {DATA_W{1'b0}};
  assign rdata_1       = rvalid_1 ? bram_dout : {DATA_W{1'b0}};
  assign grant_count_0 = cnt0_q;
  assign grant_count_1 = cnt1_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: three instances (latency 2/1/4, counter width 32/4/4) share
// one stimulus stream and are checked against a cycle-indexed issue-history model.
module tb_bram_read_arbiter;

  localparam int AW    = 17;
  localparam int DW    = 512;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;
  localparam int LAT_C = 4;
  localparam int MAXC  = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_0 = 1'b0, req_1 = 1'b0;
  logic [AW-1:0] addr_0 = 17'h0, addr_1 = 17'h0;

  logic          g0 [3], g1 [3], rv0 [3], rv1 [3];
  logic [DW-1:0] rd0 [3], rd1 [3], dout [3];
  logic [AW-1:0] baddr [3];
  logic [AW-1:0] bp [3][4];
  logic [31:0]   ca0, ca1;
  logic [3:0]    cb0, cb1, cc0, cc1;
  logic [31:0]   cnt0_w [3], cnt1_w [3];

  int            lat_of [3] = '{LAT_A, LAT_B, LAT_C};
  logic [31:0]   cmax [3]   = '{32'hFFFF_FFFF, 32'd15, 32'd15};

  // Reference state: round-robin priority, held address, counters, issue history by cycle
  bit            m_prio1;
  logic [AW-1:0] m_last_addr;
  logic [31:0]   m_cnt0 [3], m_cnt1 [3];
  bit            h_v [MAXC];
  bit            h_id [MAXC];
  logic [AW-1:0] h_a [MAXC];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  bit            e_g0, e_g1;
  logic          got_g0, got_g1, got_rv0, got_rv1;
  logic [AW-1:0] got_baddr;
  logic [DW-1:0] got_rd0;

  typedef struct {
    bit            r0;
    logic [AW-1:0] a0;
    bit            r1;
    logic [AW-1:0] a1;
    bit            g0;
    bit            g1;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    if (a == 17'h00010) return {64{8'hA5}};
    return {16{a, 15'h5A3C}};
  endfunction

  bram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT_A), .CNT_W(32)) u_a (
    .clk(clk), .reset(reset),
    .req_0(req_0), .addr_0(addr_0), .gnt_0(g0[0]), .rvalid_0(rv0[0]), .rdata_0(rd0[0]),
    .req_1(req_1), .addr_1(addr_1), .gnt_1(g1[0]), .rvalid_1(rv1[0]), .rdata_1(rd1[0]),
    .bram_addr(baddr[0]), .bram_dout(dout[0]), .grant_count_0(ca0), .grant_count_1(ca1));

  bram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT_B), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset),
    .req_0(req_0), .addr_0(addr_0), .gnt_0(g0[1]), .rvalid_0(rv0[1]), .rdata_0(rd0[1]),
    .req_1(req_1), .addr_1(addr_1), .gnt_1(g1[1]), .rvalid_1(rv1[1]), .rdata_1(rd1[1]),
    .bram_addr(baddr[1]), .bram_dout(dout[1]), .grant_count_0(cb0), .grant_count_1(cb1));

  bram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT_C), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset),
    .req_0(req_0), .addr_0(addr_0), .gnt_0(g0[2]), .rvalid_0(rv0[2]), .rdata_0(rd0[2]),
    .req_1(req_1), .addr_1(addr_1), .gnt_1(g1[2]), .rvalid_1(rv1[2]), .rdata_1(rd1[2]),
    .bram_addr(baddr[2]), .bram_dout(dout[2]), .grant_count_0(cc0), .grant_count_1(cc1));

  assign cnt0_w[0] = ca0;
  assign cnt1_w[0] = ca1;
  assign cnt0_w[1] = {28'd0, cb0};
  assign cnt1_w[1] = {28'd0, cb1};
  assign cnt0_w[2] = {28'd0, cc0};
  assign cnt1_w[2] = {28'd0, cc1};
  assign dout[0]   = word_of(bp[0][LAT_A-1]);
  assign dout[1]   = word_of(bp[1][LAT_B-1]);
  assign dout[2]   = word_of(bp[2][LAT_C-1]);

  always #5 clk = ~clk;

  // BRAM model: address sampled on each edge, data appears after the instance latency
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bp[i][0] <= baddr[i];
      for (int j = 1; j < 4; j++) bp[i][j] <= bp[i][j-1];
    end
  end

  task automatic chk(input string name, input int inst, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h exp=%0h", name, inst, cyc, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_gnt0"}, i, g0[i], 1'b0);
      chk({tag, "_gnt1"}, i, g1[i], 1'b0);
      chk({tag, "_baddr"}, i, baddr[i], 17'h0);
      chk({tag, "_rv0"}, i, rv0[i], 1'b0);
      chk({tag, "_rv1"}, i, rv1[i], 1'b0);
      chk({tag, "_rd0"}, i, rd0[i], {DW{1'b0}});
      chk({tag, "_rd1"}, i, rd1[i], {DW{1'b0}});
      chk({tag, "_cnt0"}, i, cnt0_w[i], 32'd0);
      chk({tag, "_cnt1"}, i, cnt1_w[i], 32'd0);
    end
  endtask

  // Asserts reset mid-cycle with both requests high, then clears the reference model
  task automatic do_reset();
    #3;
    reset  = 1'b1;
    req_0  = 1'b1;
    addr_0 = 17'h00030;
    req_1  = 1'b1;
    addr_1 = 17'h00031;
    #1;
    check_reset_state("rst_early");
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_held");
    @(negedge clk);
    reset = 1'b0;
    req_0 = 1'b0;
    req_1 = 1'b0;
    m_prio1     = 1'b0;
    m_last_addr = 17'h0;
    for (int i = 0; i < 3; i++) begin
      m_cnt0[i] = 32'd0;
      m_cnt1[i] = 32'd0;
    end
    for (int t = 0; t < cyc; t++) h_v[t] = 1'b0;
  endtask

  // One cycle: drive, compare everything against the model, then advance the model
  task automatic step(input bit r0, input logic [AW-1:0] a0, input bit r1,
                      input logic [AW-1:0] a1);
    logic [AW-1:0] eaddr;
    bit            ev0, ev1;
    logic [DW-1:0] ed;
    int            t;
    @(negedge clk);
    req_0  = r0;
    addr_0 = a0;
    req_1  = r1;
    addr_1 = a1;
    #1;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (r0 && r1) begin
      if (m_prio1) e_g1 = 1'b1;
      else         e_g0 = 1'b1;
    end else if (r0) e_g0 = 1'b1;
    else if (r1)     e_g1 = 1'b1;
    eaddr = e_g0 ? a0 : (e_g1 ? a1 : m_last_addr);
    for (int i = 0; i < 3; i++) begin
      t   = cyc - lat_of[i];
      ev0 = 1'b0;
      ev1 = 1'b0;
      ed  = {DW{1'b0}};
      if (t >= 0 && h_v[t]) begin
        ev0 = !h_id[t];
        ev1 = h_id[t];
        ed  = word_of(h_a[t]);
      end
      chk("gnt_0", i, g0[i], e_g0);
      chk("gnt_1", i, g1[i], e_g1);
      chk("bram_addr", i, baddr[i], eaddr);
      chk("rvalid_0", i, rv0[i], ev0);
      chk("rvalid_1", i, rv1[i], ev1);
      chk("rdata_0", i, rd0[i], ev0 ? ed : {DW{1'b0}});
      chk("rdata_1", i, rd1[i], ev1 ? ed : {DW{1'b0}});
      chk("count_0", i, cnt0_w[i], m_cnt0[i]);
      chk("count_1", i, cnt1_w[i], m_cnt1[i]);
      if (e_g0 && m_cnt0[i] < cmax[i]) m_cnt0[i] = m_cnt0[i] + 32'd1;
      if (e_g1 && m_cnt1[i] < cmax[i]) m_cnt1[i] = m_cnt1[i] + 32'd1;
    end
    got_g0    = g0[0];
    got_g1    = g1[0];
    got_rv0   = rv0[0];
    got_rv1   = rv1[0];
    got_rd0   = rd0[0];
    got_baddr = baddr[0];
    if (cyc < MAXC) begin
      h_v[cyc]  = e_g0 | e_g1;
      h_id[cyc] = e_g1;
      h_a[cyc]  = eaddr;
    end
    if (e_g0)      m_prio1 = 1'b1;
    else if (e_g1) m_prio1 = 1'b0;
    if (e_g0 || e_g1) m_last_addr = eaddr;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    logic [DW-1:0] a5w;
    bit            cr0, cr1;
    logic [AW-1:0] ca0_s, ca1_s;
    a5w = {64{8'hA5}};

    // Contention (6 cycles), drain, back-to-back on port 1 (8 cycles), drain
    tbl.push_back('{1'b1, 17'h1, 1'b1, 17'h4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 17'h2, 1'b1, 17'h4, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 17'h2, 1'b1, 17'h5, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 17'h3, 1'b1, 17'h5, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 17'h3, 1'b1, 17'h6, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 17'h7, 1'b1, 17'h6, 1'b0, 1'b1});
    for (int k = 0; k < 5; k++) tbl.push_back('{1'b0, 17'h0, 1'b0, 17'h0, 1'b0, 1'b0});
    for (int k = 0; k < 8; k++)
      tbl.push_back('{1'b0, 17'h0, 1'b1, 17'h100 + 17'(k), 1'b0, 1'b1});
    for (int k = 0; k < 5; k++) tbl.push_back('{1'b0, 17'h0, 1'b0, 17'h0, 1'b0, 1'b0});

    // Single requester, data returned exactly two cycles later on instance A
    do_reset();
    step(1'b1, 17'h00010, 1'b0, 17'h0);
    chk("single_gnt0", 0, got_g0, 1'b1);
    chk("single_baddr", 0, got_baddr, 17'h00010);
    step(1'b0, 17'h0, 1'b0, 17'h0);
    chk("single_rv0_t1", 0, got_rv0, 1'b0);
    step(1'b0, 17'h0, 1'b0, 17'h0);
    chk("single_rv0_t2", 0, got_rv0, 1'b1);
    chk("single_rd0_t2", 0, got_rd0, a5w);
    chk("single_rv1_t2", 0, got_rv1, 1'b0);
    chk("single_cnt0", 0, ca0, 32'd1);

    // Table-driven contention and back-to-back sequences
    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k].r0, tbl[k].a0, tbl[k].r1, tbl[k].a1);
      chk("tbl_gnt0", k, got_g0, tbl[k].g0);
      chk("tbl_gnt1", k, got_g1, tbl[k].g1);
    end
    chk("tbl_cnt0", 0, ca0, 32'd3);
    chk("tbl_cnt1", 0, ca1, 32'd11);

    // Reset one cycle after an issue: the in-flight read must never return
    do_reset();
    step(1'b1, 17'h00020, 1'b0, 17'h0);
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b0, 17'h0, 1'b0, 17'h0);
    chk("midrst_cnt0", 0, ca0, 32'd0);

    // Saturation of the 4-bit counters
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1, 17'h200 + 17'(k), 1'b0, 17'h0);
    #1;
    chk("sat_cnt0_b", 1, cnt0_w[1], 32'd15);
    chk("sat_cnt0_c", 2, cnt0_w[2], 32'd15);
    chk("sat_cnt0_a", 0, cnt0_w[0], 32'd20);

    // Randomized traffic honouring the hold-until-granted handshake
    cr0   = 1'b0;
    cr1   = 1'b0;
    ca0_s = 17'h0;
    ca1_s = 17'h0;
    for (int k = 0; k < 400; k++) begin
      step(cr0, ca0_s, cr1, ca1_s);
      if (!cr0 || e_g0) begin
        cr0   = ($urandom_range(0, 3) != 0);
        ca0_s = 17'($urandom);
      end
      if (!cr1 || e_g1) begin
        cr1   = ($urandom_range(0, 3) != 0);
        ca1_s = 17'($urandom);
      end
    end
    for (int k = 0; k < 5; k++) step(1'b0, 17'h0, 1'b0, 17'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_read_arbiter.md
Name: bram_read_arbiter

Overview:
- Shares the single read port of the CSR-graph block RAM between two CSR traversal engines, e.g. the lo-byte and hi-byte input-stream engines.
- Performs round-robin arbitration, drives the BRAM address and returns each read beat only to the requester that issued it, after a fixed BRAM read latency.
- Keeps per-requester grant counters for cycle and throughput accounting in the simulation bench.

Parameters:
- ADDR_W, 17, BRAM word address width.
- DATA_W, 512, BRAM read-data width.
- RD_LATENCY, 2, clock edges from address sample to valid bram_dout; legal range 1..4.
- CNT_W, 32, width of each grant counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_0  in  1  read request, requester 0.
- addr_0  in  ADDR_W  read address, requester 0.
- gnt_0  out  1  grant, requester 0; combinational.
- rvalid_0  out  1  read data valid, requester 0.
- rdata_0  out  DATA_W  read data, requester 0.
- req_1  in  1  read request, requester 1.
- addr_1  in  ADDR_W  read address, requester 1.
- gnt_1  out  1  grant, requester 1; combinational.
- rvalid_1  out  1  read data valid, requester 1.
- rdata_1  out  DATA_W  read data, requester 1.
- bram_addr  out  ADDR_W  BRAM port A address.
- bram_dout  in  DATA_W  BRAM port A read data.
- grant_count_0  out  CNT_W  reads issued for requester 0.
- grant_count_1  out  CNT_W  reads issued for requester 1.

Behaviour:
- Handshake: a requester holds req_k and addr_k stable until it samples gnt_k=1 at a rising edge. A read issues in the cycle T where req_k & gnt_k = 1. A requester may keep req_k high for back-to-back reads, one per grant.
- Arbitration, from registered pointer rr_ptr:
  - Only one req high: that requester is granted.
  - Both high: requester rr_ptr is granted.
  - No req: no grant.
  - gnt_0 and gnt_1 are never both 1.
- Pointer update: after any grant to k, rr_ptr <= 1-k. With no grant, rr_ptr holds. Under continuous contention grants alternate, so a waiting requester is granted within 1 cycle.
- bram_addr is combinational:
  - In an issue cycle, it equals the granted addr_k.
  - Otherwise it equals last_addr, a register updated with the issued address on every grant.
- Response pipeline:
  - A RD_LATENCY-deep shift register of {valid, id}. Stage 0 is loaded with {1, k} on a grant, {0, x} otherwise.
  - rvalid_k = 1 in cycle T+RD_LATENCY exactly when the tail is {1, k}.
  - rdata_k = bram_dout while rvalid_k = 1, otherwise all zeros.
  - Throughput is one read per cycle in total, and responses return in issue order.
- Counters: grant_count_k increments by 1 on each grant to k and saturates at 2^CNT_W-1 (no wrap).
- Reset values, asserted asynchronously: gnt_0 and gnt_1 forced 0 while reset is high, rr_ptr = 0, last_addr = 0, bram_addr = 0, all pipeline valid bits 0, rvalid_0/1 = 0, rdata_0/1 = 0, grant_count_0/1 = 0.
- Reset mid-operation: in-flight reads are discarded and produce no rvalid after reset deasserts. The first grant after reset follows normal arbitration with rr_ptr = 0.
- Simultaneous events:
  - A grant in cycle T and a response delivered in cycle T, possibly to the same requester, are independent and both take effect.
  - A counter at saturation ignores further grants and still reports the maximum value.
- X handling: req_k high with addr_k containing X is a requester error and is not required to be handled.

Test Plan:
- Single requester: reset, then req_0 = 1 with addr_0 = 0x00010 for 1 cycle, BRAM preloaded with word[0x10] = 0xA5..A5 -> gnt_0 = 1 in T; bram_addr = 0x00010; rvalid_0 = 1 with rdata_0 = 0xA5..A5 at exactly T+2; rvalid_1 stays 0; grant_count_0 = 1.
- Contention: req_0 and req_1 held high for 6 cycles with addresses 0x1..0x6 per port -> grant order 0,1,0,1,0,1; each rvalid appears 2 cycles after its grant with the matching word; both counts = 3.
- Back-to-back single port: req_1 high for 8 cycles with addr_1 = 0x100..0x107 -> 8 consecutive gnt_1; rvalid_1 high for 8 consecutive cycles, in order, starting at the 3rd cycle.
- Reset mid-flight: grant addr 0x20, then assert reset 1 cycle later (async, mid-cycle) -> no rvalid_0 at any later cycle; counters = 0; bram_addr = 0 during reset.
- Saturation: CNT_W = 4, req_0 high for 20 cycles -> grant_count_0 reaches 15 and holds at 15.
- Parameter sweep: RD_LATENCY = 1 and RD_LATENCY = 4 with the contention scenario -> response offset equals RD_LATENCY; per-port order preserved.
